ldn_cn_min2_acc: RTL and testbench

Check-node min-sum accumulator that sits directly downstream of the ALU's packed 8-bit SIMD LDPC operations. It consumes a stream of `deg` packed SIMD message words (one ALU result per beat). For each lane it tracks the smallest and second-smallest magnitude, the beat index of the smallest, and the running sign parity. When the check node is complete, it presents the packed result to the write-back/decoder-memory stage over a valid/ready handshake.

---
 rtl/ldn_cn_min2_acc.sv | 149 ++++++++++++++
 tb/tb_ldn_cn_min2_acc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ldn_cn_min2_acc.sv
// Per-lane min-sum check-node accumulator: tracks min1/min2/argmin/sign parity over deg SIMD beats.
// Define LDN_CN_OFFSET_EN to subtract OFFSET (floored at 0) from min1/min2 when the result is registered.
module ldn_cn_min2_acc #(
  parameter int Q       = 8,
  parameter int SIMD    = 8,
  parameter int MAX_DEG = 16,
  parameter int IDX_W   = $clog2(MAX_DEG),
  parameter int OFFSET  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [$clog2(MAX_DEG+1)-1:0]  deg_i,
  output logic                          err_o,
  output logic                          busy_o,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [Q*SIMD-1:0]             in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [Q*SIMD-1:0]             min1_o,
  output logic [Q*SIMD-1:0]             min2_o,
  output logic [IDX_W*SIMD-1:0]         idx_o,
  output logic [SIMD-1:0]               sgn_o
);

  localparam int W     = Q * SIMD;
  localparam int DEG_W = $clog2(MAX_DEG + 1);
  localparam logic [Q-1:0] MAX_MAG = {1'b0, {(Q-1){1'b1}}};
  localparam logic [Q-1:0] ONE     = {{(Q-1){1'b0}}, 1'b1};
`ifdef LDN_CN_OFFSET_EN
  localparam logic [Q-1:0] OFF = Q'(OFFSET);
`endif

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, last_q;
  logic [W-1:0]           acc_min1_q, acc_min2_q, acc_min1_d, acc_min2_d;
  logic [W-1:0]           fin_min1, fin_min2;
  logic [IDX_W*SIMD-1:0]  acc_idx_q, acc_idx_d;
  logic [SIMD-1:0]        acc_sgn_q, acc_sgn_d;
  logic [Q-1:0]           mag [SIMD];
  logic                   deg_ok, accept_start, beat, last_beat;

  function automatic logic [Q-1:0] lane_offset(input logic [Q-1:0] v);
`ifdef LDN_CN_OFFSET_EN
    return (v > OFF) ? (v - OFF) : '0;
`else
    return v;
`endif
  endfunction

  assign deg_ok       = (deg_i >= DEG_W'(2)) && (deg_i <= DEG_W'(MAX_DEG));
  assign accept_start = (state_q == IDLE) && start_i && deg_ok;
  assign beat         = (state_q == ACC) && in_valid_i;
  assign last_beat    = beat && (cnt_q == last_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy_o      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: if (accept_start) state_d = ACC;
      ACC: begin
        busy_o     = 1'b1;
        in_ready_o = 1'b1;
        if (last_beat) state_d = OUT;
      end
      OUT: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Candidate per-lane update for the beat on in_data_i; -2^(Q-1) saturates to the max magnitude.
  always_comb begin
    acc_min1_d = acc_min1_q;
    acc_min2_d = acc_min2_q;
    acc_idx_d  = acc_idx_q;
    acc_sgn_d  = acc_sgn_q;
    fin_min1   = '0;
    fin_min2   = '0;
    for (int l = 0; l < SIMD; l++) begin
      if (!in_data_i[l*Q+Q-1])                 mag[l] = in_data_i[l*Q +: Q];
      else if (in_data_i[l*Q +: Q-1] == '0)    mag[l] = MAX_MAG;
      else                                     mag[l] = ~in_data_i[l*Q +: Q] + ONE;
      if (mag[l] < acc_min1_q[l*Q +: Q]) begin
        acc_min2_d[l*Q +: Q]         = acc_min1_q[l*Q +: Q];
        acc_min1_d[l*Q +: Q]         = mag[l];
        acc_idx_d[l*IDX_W +: IDX_W]  = cnt_q;
      end else if (mag[l] < acc_min2_q[l*Q +: Q]) begin
        acc_min2_d[l*Q +: Q] = mag[l];
      end
      acc_sgn_d[l]       = acc_sgn_q[l] ^ in_data_i[l*Q+Q-1];
      fin_min1[l*Q +: Q] = lane_offset(acc_min1_d[l*Q +: Q]);
      fin_min2[l*Q +: Q] = lane_offset(acc_min2_d[l*Q +: Q]);
    end
  end

  // Result registers only load on the final beat so they persist across idle periods.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      last_q     <= '0;
      acc_min1_q <= '0;
      acc_min2_q <= '0;
      acc_idx_q  <= '0;
      acc_sgn_q  <= '0;
      min1_o     <= '0;
      min2_o     <= '0;
      idx_o      <= '0;
      sgn_o      <= '0;
      err_o      <= 1'b0;
    end else begin
      err_o <= (state_q == IDLE) && start_i && !deg_ok;
      if (accept_start) begin
        cnt_q      <= '0;
        last_q     <= IDX_W'(deg_i - DEG_W'(1));
        acc_min1_q <= {SIMD{MAX_MAG}};
        acc_min2_q <= {SIMD{MAX_MAG}};
        acc_idx_q  <= '0;
        acc_sgn_q  <= '0;
      end else if (beat) begin
        cnt_q      <= cnt_q + IDX_W'(1);
        acc_min1_q <= acc_min1_d;
        acc_min2_q <= acc_min2_d;
        acc_idx_q  <= acc_idx_d;
        acc_sgn_q  <= acc_sgn_d;
        if (last_beat) begin
          min1_o <= fin_min1;
          min2_o <= fin_min2;
          idx_o  <= acc_idx_d;
          sgn_o  <= acc_sgn_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldn_cn_min2_acc.sv
// Directed self-checking bench for ldn_cn_min2_acc (default parameters).
// Expected min values are adjusted for LDN_CN_OFFSET_EN when that macro is defined.
module tb_ldn_cn_min2_acc;

`ifdef LDN_CN_OFFSET_EN
  localparam logic [7:0] OFF_V = 8'd1;
`else
  localparam logic [7:0] OFF_V = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [4:0]  deg_i = '0;
  logic        err_o, busy_o, in_ready_o, out_valid_o;
  logic        in_valid_i = 1'b0;
  logic [63:0] in_data_i = '0;
  logic        out_ready_i = 1'b0;
  logic [63:0] min1_o, min2_o;
  logic [31:0] idx_o;
  logic [7:0]  sgn_o;
  logic [3:0]  status;

  int    check_cnt = 0;
  int    pass_cnt  = 0;
  string phase     = "reset";

  ldn_cn_min2_acc dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start_i),
    .deg_i       (deg_i),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .min1_o      (min1_o),
    .min2_o      (min2_o),
    .idx_o       (idx_o),
    .sgn_o       (sgn_o)
  );

  always #5 clk = ~clk;

  assign status = {err_o, busy_o, in_ready_o, out_valid_o};

  function automatic logic [63:0] offs(input logic [63:0] v);
    logic [63:0] r;
    logic [7:0]  b;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      b = v[l*8 +: 8];
      r[l*8 +: 8] = (b > OFF_V) ? (b - OFF_V) : 8'd0;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s/%s: got %h expected %h", phase, tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startNode(input logic [4:0] d);
    start_i = 1'b1;
    deg_i   = d;
    step();
    start_i = 1'b0;
    checkOutput("start_status", 64'(status), 64'(4'b0110));
  endtask

  // One beat, followed by `gap` idle cycles during which the accumulator must stall.
  task automatic applyStimulus(input logic [63:0] data, input int gap);
    in_valid_i = 1'b1;
    in_data_i  = data;
    step();
    in_valid_i = 1'b0;
    in_data_i  = '0;
    for (int g = 0; g < gap; g++) begin
      checkOutput("stall_status", 64'(status), 64'(4'b0110));
      step();
    end
  endtask

  task automatic expectResult(input logic [63:0] e1, input logic [63:0] e2,
                              input logic [31:0] ei, input logic [7:0] es);
    checkOutput("out_status", 64'(status), 64'(4'b0101));
    checkOutput("min1", min1_o, offs(e1));
    checkOutput("min2", min2_o, offs(e2));
    checkOutput("idx", 64'(idx_o), 64'(ei));
    checkOutput("sgn", 64'(sgn_o), 64'(es));
  endtask

  task automatic finishNode(input logic [63:0] e1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    checkOutput("idle_status", 64'(status), 64'(4'b0000));
    checkOutput("min1_hold", min1_o, offs(e1));
  endtask

  task automatic checkAllZero();
    checkOutput("rst_status", 64'(status), 64'(4'b0000));
    checkOutput("rst_min1", min1_o, 64'h0);
    checkOutput("rst_min2", min2_o, 64'h0);
    checkOutput("rst_idx", 64'(idx_o), 64'h0);
    checkOutput("rst_sgn", 64'(sgn_o), 64'h0);
  endtask

  initial begin
    #2;
    checkAllZero();
    step();
    step();
    rst = 1'b0;
    step();

    // lane0: +5 -3 +7 -2, other lanes 0
    phase = "basic";
    startNode(5'd4);
    applyStimulus(64'h05, 0);
    applyStimulus(64'hFD, 0);
    applyStimulus(64'h07, 0);
    checkOutput("pre_last_valid", 64'(out_valid_o), 64'h0);
    applyStimulus(64'hFE, 0);
    expectResult(64'h02, 64'h03, 32'h3, 8'h00);
    finishNode(64'h02);

    // all lanes -128 twice: saturates to 127, even sign parity
    phase = "saturate";
    startNode(5'd2);
    applyStimulus(64'h8080_8080_8080_8080, 0);
    applyStimulus(64'h8080_8080_8080_8080, 0);
    expectResult(64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F, 32'h0, 8'h00);
    finishNode(64'h7F7F_7F7F_7F7F_7F7F);

    // back-to-back: lane7 -1 +9 +9
    phase = "lane7";
    startNode(5'd3);
    applyStimulus(64'hFF00_0000_0000_0000, 0);
    applyStimulus(64'h0900_0000_0000_0000, 0);
    applyStimulus(64'h0900_0000_0000_0000, 0);
    expectResult(64'h0100_0000_0000_0000, 64'h0900_0000_0000_0000, 32'h0, 8'h80);
    finishNode(64'h0100_0000_0000_0000);

    // ties with input gaps, then backpressure
    phase = "ties";
    startNode(5'd3);
    applyStimulus(64'h0404_0404_0404_0404, 2);
    applyStimulus(64'h0404_0404_0404_0404, 3);
    applyStimulus(64'h0404_0404_0404_0404, 0);
    expectResult(64'h0404_0404_0404_0404, 64'h0404_0404_0404_0404, 32'h0, 8'h00);
    phase = "backpressure";
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start_i = 1'b1;
        deg_i   = 5'd2;
      end
      step();
      start_i = 1'b0;
      checkOutput("bp_status", 64'(status), 64'(4'b0101));
      checkOutput("bp_min2", min2_o, offs(64'h0404_0404_0404_0404));
    end
    finishNode(64'h0404_0404_0404_0404);

    // illegal degrees: one err pulse each, no state change
    phase = "illegal";
    for (int i = 0; i < 3; i++) begin
      start_i = 1'b1;
      deg_i   = (i == 0) ? 5'd1 : (i == 1) ? 5'd0 : 5'd17;
      step();
      start_i = 1'b0;
      checkOutput("err_pulse", 64'(status), 64'(4'b1000));
      step();
      checkOutput("err_clear", 64'(status), 64'(4'b0000));
    end

    // reset mid-run, then a clean deg=2 run (lane1 stays at magnitude 0)
    phase = "reset_mid";
    startNode(5'd4);
    applyStimulus(64'h0101_0101_0101_0101, 0);
    applyStimulus(64'h0202_0202_0202_0202, 0);
    rst = 1'b1;
    #1;
    checkAllZero();
    step();
    rst = 1'b0;
    step();
    phase = "after_reset";
    startNode(5'd2);
    applyStimulus(64'h0606_0606_0606_0006, 0);
    applyStimulus(64'h0808_0808_0808_0008, 0);
    expectResult(64'h0606_0606_0606_0006, 64'h0808_0808_0808_0008, 32'h0, 8'h00);
    finishNode(64'h0606_0606_0606_0006);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
